// File: rtl/tt_um_en_arbiter_pkg.sv
// Shared types and constants for the enable-gated round-robin arbiter tile.
package tt_um_en_arbiter_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    // Number of requesters handled by the tile.
    localparam int NREQ = 4;

    // Hold counter width; wide enough for a MAX_HOLD of up to 15.
    localparam int HOLD_W = 4;

    // ui_in field positions.
    localparam int UI_REQ_LSB  = 0;
    localparam int UI_REL      = 4;

    // uo_out field positions.
    localparam int UO_GNT_LSB  = 0;
    localparam int UO_BUSY     = 4;
    localparam int UO_GIDX_LSB = 5;
    localparam int UO_TOUT     = 7;

    // One-hot encoding of a requester index.
    function automatic logic [NREQ-1:0] onehot_idx(input logic [1:0] idx);
        logic [NREQ-1:0] v;
        v      = '0;
        v[idx] = 1'b1;
        return v;
    endfunction

endpackage

// File: rtl/en_rr_pick.sv
// Combinational 4-way round-robin picker: first asserted request found
// when scanning upward from ptr, wrapping 3 -> 0.
module en_rr_pick
    import tt_um_en_arbiter_pkg::*;
(
    input  logic [NREQ-1:0] req,
    input  logic [1:0]      ptr,
    output logic            valid,
    output logic [1:0]      idx
);

    logic [1:0]      cand [NREQ];
    logic [NREQ-1:0] rot;

    // Rotate the request vector so position 0 is the highest-priority slot.
    generate
        for (genvar gi = 0; gi < NREQ; gi++) begin : g_rot
            assign cand[gi] = ptr + 2'(gi);
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    // Scan from lowest priority to highest so the highest-priority hit wins.
    always_comb begin
        idx = ptr;
        for (int k = NREQ - 1; k >= 0; k--) begin
            if (rot[k]) begin
                idx = cand[k];
            end
        end
    end

    assign valid = |req;

endmodule

// File: rtl/tt_um_en_arbiter.sv
// Round-robin arbiter tile: one grant at a time, released by the owner,
// by the owner dropping its request, or forcibly after MAX_HOLD cycles.
module tt_um_en_arbiter #(
    parameter int MAX_HOLD = 8,
    parameter int NREQ     = tt_um_en_arbiter_pkg::NREQ
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic [7:0] ui_in,
    output logic [7:0] uo_out,
    input  logic [7:0] uio_in,
    output logic [7:0] uio_out,
    output logic [7:0] uio_oe
);

    import tt_um_en_arbiter_pkg::*;

    localparam logic [HOLD_W-1:0] HOLD_LIM = HOLD_W'(MAX_HOLD - 1);

    state_t              state_reg, state_next;
    logic [HOLD_W-1:0]   hold_reg,  hold_next;
    logic [1:0]          ptr_reg,   ptr_next;
    logic [1:0]          gidx_reg,  gidx_next;
    logic [NREQ-1:0]     gnt_reg,   gnt_next;
    logic                busy_reg,  busy_next;
    logic                tout_reg,  tout_next;
    logic [7:0]          cnt_reg,   cnt_next;

    logic [NREQ-1:0]     req;
    logic                rel;
    logic                pick_valid;
    logic [1:0]          pick_idx;
    logic                at_limit;
    logic                owner_req;
    logic                unused_pins;

    assign req       = ui_in[UI_REQ_LSB +: NREQ];
    assign rel       = ui_in[UI_REL];
    assign at_limit  = (hold_reg == HOLD_LIM);
    assign owner_req = req[gidx_reg];

    en_rr_pick u_pick (
        .req   (req),
        .ptr   (ptr_reg),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    // State and output registers; ena low freezes everything, including tout.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= IDLE;
            hold_reg  <= '0;
            ptr_reg   <= '0;
            gidx_reg  <= '0;
            gnt_reg   <= '0;
            busy_reg  <= 1'b0;
            tout_reg  <= 1'b0;
            cnt_reg   <= '0;
        end else if (ena) begin
            state_reg <= state_next;
            hold_reg  <= hold_next;
            ptr_reg   <= ptr_next;
            gidx_reg  <= gidx_next;
            gnt_reg   <= gnt_next;
            busy_reg  <= busy_next;
            tout_reg  <= tout_next;
            cnt_reg   <= cnt_next;
        end
    end

    // Next-state logic: arbitrate in IDLE, supervise the owner in GRANT.
    always_comb begin
        state_next = state_reg;
        hold_next  = hold_reg;
        ptr_next   = ptr_reg;
        gidx_next  = gidx_reg;
        gnt_next   = gnt_reg;
        busy_next  = busy_reg;
        tout_next  = 1'b0;
        cnt_next   = cnt_reg;
        case (state_reg)
            IDLE: begin
                // rel is meaningless without an owner and is ignored here.
                if (pick_valid) begin
                    state_next = GRANT;
                    gnt_next   = onehot_idx(pick_idx);
                    gidx_next  = pick_idx;
                    busy_next  = 1'b1;
                    hold_next  = '0;
                    cnt_next   = cnt_reg + 8'd1;
                end else begin
                    gnt_next  = '0;
                    busy_next = 1'b0;
                end
            end
            GRANT: begin
                if (rel || !owner_req || at_limit) begin
                    state_next = IDLE;
                    gnt_next   = '0;
                    busy_next  = 1'b0;
                    ptr_next   = gidx_reg + 2'd1;
                    // Only a pure hold-limit exit is reported as a timeout.
                    tout_next  = at_limit && !rel && owner_req;
                end else begin
                    // Exit fires at the limit, so this never passes HOLD_LIM.
                    hold_next = hold_reg + 1'b1;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Pin mapping of the registered outputs.
    always_comb begin
        uo_out                           = '0;
        uo_out[UO_GNT_LSB +: NREQ]       = gnt_reg;
        uo_out[UO_BUSY]                  = busy_reg;
        uo_out[UO_GIDX_LSB +: 2]         = gidx_reg;
        uo_out[UO_TOUT]                  = tout_reg;
    end

    assign uio_out = cnt_reg;
    assign uio_oe  = 8'hFF;

    assign unused_pins = &{1'b0, uio_in, ui_in[7:5]};

endmodule

// File: tb/tb_tt_um_en_arbiter.sv
// Directed bench for the round-robin arbiter tile with a scoreboard queue.
module tb_tt_um_en_arbiter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    int n_checks = 0;
    int n_fails  = 0;

    logic [23:0] exp_q[$];

    tt_um_en_arbiter #(.MAX_HOLD(8)) dut (
        .clk     (clk),
        .rst_n   (rst_n),
        .ena     (ena),
        .ui_in   (ui_in),
        .uo_out  (uo_out),
        .uio_in  (uio_in),
        .uio_out (uio_out),
        .uio_oe  (uio_oe)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] mk_uo(input logic [3:0] g, input logic b,
                                         input logic [1:0] i, input logic t);
        return {t, i, b, g};
    endfunction

    task automatic check(input string tag, input logic [23:0] exp);
        logic [23:0] obs;
        obs = {uio_oe, uio_out, uo_out};
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed oe/cnt/uo=%h expected %h", tag, obs, exp);
        end
    endtask

    // Drive one cycle of stimulus, queue the expected response, and
    // compare it once the DUT has registered it.
    task automatic step(input string tag, input logic [7:0] ui,
                        input logic [7:0] exp_uo, input logic [7:0] exp_cnt);
        logic [23:0] e;
        ui_in = ui;
        exp_q.push_back({8'hFF, exp_cnt, exp_uo});
        @(posedge clk);
        #1;
        e = exp_q.pop_front();
        check(tag, e);
        $display("step %-10s ui=%h uo=%h cnt=%h", tag, ui, uo_out, uio_out);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [1:0] prev;
        logic [1:0] k;
        logic [3:0] oh;
        logic [7:0] c;

        rst_n  = 1'b0;
        ena    = 1'b1;
        ui_in  = 8'h00;
        uio_in = 8'h00;

        // Reset state, outputs valid while in reset.
        #12;
        check("reset", {8'hFF, 8'h00, 8'h00});
        @(negedge clk);
        rst_n = 1'b1;

        // First arbitration favours requester 0.
        step("first", 8'h0F, mk_uo(4'b0001, 1'b1, 2'd0, 1'b0), 8'd1);

        // Rotation with rel pulsed on every grant.
        prev = 2'd0;
        c    = 8'd1;
        for (int i = 1; i <= 4; i++) begin
            k  = 2'(i);
            oh = 4'b0001 << k;
            step("rr_exit", 8'h1F, mk_uo(4'b0000, 1'b0, prev, 1'b0), c);
            c = c + 8'd1;
            step("rr_grant", 8'h0F, mk_uo(oh, 1'b1, k, 1'b0), c);
            prev = k;
        end
        step("rr_exit", 8'h1F, mk_uo(4'b0000, 1'b0, 2'd0, 1'b0), 8'd5);

        // rel with nobody owning is ignored.
        step("idle_rel", 8'h10, mk_uo(4'b0000, 1'b0, 2'd0, 1'b0), 8'd5);

        // Hold limit: 8 grant cycles, then a single tout cycle.
        for (int i = 0; i < 8; i++) begin
            step("hold", 8'h04, mk_uo(4'b0100, 1'b1, 2'd2, 1'b0), 8'd6);
        end
        step("tout", 8'h04, mk_uo(4'b0000, 1'b0, 2'd2, 1'b1), 8'd6);
        step("tout_end", 8'h00, mk_uo(4'b0000, 1'b0, 2'd2, 1'b0), 8'd6);

        // Owner drops req in the cycle hold is at the limit: no tout.
        for (int i = 0; i < 8; i++) begin
            step("drop_hold", 8'h02, mk_uo(4'b0010, 1'b1, 2'd1, 1'b0), 8'd7);
        end
        step("drop_exit", 8'h00, mk_uo(4'b0000, 1'b0, 2'd1, 1'b0), 8'd7);
        step("drop_idle", 8'h00, mk_uo(4'b0000, 1'b0, 2'd1, 1'b0), 8'd7);

        // ena low during GRANT freezes outputs and hold.
        for (int i = 0; i < 3; i++) begin
            step("pre_freeze", 8'h08, mk_uo(4'b1000, 1'b1, 2'd3, 1'b0), 8'd8);
        end
        ena = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step("freeze", 8'h18, mk_uo(4'b1000, 1'b1, 2'd3, 1'b0), 8'd8);
        end
        ena = 1'b1;
        for (int i = 0; i < 5; i++) begin
            step("post_frz", 8'h08, mk_uo(4'b1000, 1'b1, 2'd3, 1'b0), 8'd8);
        end
        step("frz_tout", 8'h08, mk_uo(4'b0000, 1'b0, 2'd3, 1'b1), 8'd8);
        ena = 1'b0;
        for (int i = 0; i < 2; i++) begin
            step("tout_held", 8'h00, mk_uo(4'b0000, 1'b0, 2'd3, 1'b1), 8'd8);
        end
        ena = 1'b1;
        step("tout_clr", 8'h00, mk_uo(4'b0000, 1'b0, 2'd3, 1'b0), 8'd8);

        // Asynchronous reset in the middle of a grant.
        step("pre_rst", 8'h01, mk_uo(4'b0001, 1'b1, 2'd0, 1'b0), 8'd9);
        #2;
        rst_n = 1'b0;
        #1;
        check("async_rst", {8'hFF, 8'h00, 8'h00});
        #2;
        rst_n = 1'b1;
        step("post_rst", 8'h08, mk_uo(4'b1000, 1'b1, 2'd3, 1'b0), 8'd1);

        // Grant counter wraps 255 -> 0.
        c = 8'd1;
        for (int i = 0; i < 255; i++) begin
            step("wrap_exit", 8'h18, mk_uo(4'b0000, 1'b0, 2'd3, 1'b0), c);
            c = c + 8'd1;
            step("wrap_grant", 8'h08, mk_uo(4'b1000, 1'b1, 2'd3, 1'b0), c);
        end
        step("wrap_zero", 8'h18, mk_uo(4'b0000, 1'b0, 2'd3, 1'b0), 8'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule

// File: doc/tt_um_en_arbiter.md
TT_UM_EN_ARBITER -- requirements
Module: tt_um_en_arbiter

Interface
REQ-001 Parameter MAX_HOLD, default 8, max cycles one grant may be held before forced release (range 2..15).
REQ-002 Parameter NREQ, default 4, number of requesters; fixed at 4 for this tile.
REQ-003 clk  input  1  single clock; all state on its rising edge.
REQ-004 rst_n  input  1  reset, asynchronous assert, active-low.
REQ-005 ena  input  1  tile enable; low freezes all state.
REQ-006 ui_in  input  8  [3:0] req, one bit per requester; [4] rel, release from current owner; [7:5] unused.
REQ-007 uo_out  output  8  [3:0] gnt, one-hot; [4] busy; [6:5] gidx, binary owner index; [7] tout, timeout pulse.
REQ-008 uio_in  input  8  unused.
REQ-009 uio_out  output  8  grant counter, 8-bit.
REQ-010 uio_oe  output  8  constant 8'hFF.

Function
REQ-011 FSM with two states: IDLE and GRANT; gnt, busy, gidx, tout and the counter SHALL all be registered.
REQ-012 IDLE, any req set: select the winner round-robin starting at ptr, ascending and wrapping 3->0; at the next edge enter GRANT with gnt one-hot for the winner, gidx = winner, busy=1, hold=0 and counter+1.
REQ-013 IDLE, no req set: remain in IDLE with gnt=0 and busy=0.
REQ-014 GRANT: hold increments by 1 each cycle, saturating at MAX_HOLD-1.
REQ-015 GRANT exits to IDLE at the next edge when any of these holds: rel=1, owner req=0, or hold = MAX_HOLD-1.
REQ-016 On GRANT exit: gnt=0, busy=0, ptr = (gidx+1) mod 4; gidx keeps its last value.
REQ-017 tout SHALL be 1 for exactly the one cycle after exit; it is set only by the hold-limit cause, and rel or req-drop take precedence over the limit in the same cycle.
REQ-018 Every GRANT exit is followed by at least one IDLE cycle, so back-to-back grants are 1 cycle apart and no cycle has two gnt bits set.
REQ-019 Requests from non-owners during GRANT are ignored until IDLE.
REQ-020 rel=1 in IDLE SHALL be ignored.
REQ-021 Arbitration latency: a req sampled in IDLE at edge n gives gnt at edge n+1.
REQ-022 The counter wraps 255->0 with no flag.
REQ-023 ena=0 SHALL hold FSM, hold, ptr, outputs and counter unchanged; a pending tout pulse stays held until ena=1.

Reset
REQ-024 rst_n=0 SHALL asynchronously force: state=IDLE, gnt=0, busy=0, gidx=0, tout=0, hold=0, ptr=0, counter=0.
REQ-025 Reset during GRANT drops the grant immediately, without waiting for a clock edge.
REQ-026 Outputs SHALL be valid while rst_n=0; uio_oe=8'hFF at all times.
REQ-027 The first arbitration after reset favours requester 0.

Structure
REQ-028 A shared package SHALL hold: the state enum (IDLE, GRANT), NREQ, the hold-counter width, and the uo_out bit-position constants.
REQ-029 One sub-module, en_rr_pick: combinational 4-way round-robin picker, inputs req[3:0] and ptr[1:0], outputs valid and idx[1:0].
REQ-030 The top level contains the FSM, hold counter, ptr register, grant counter and pin mapping.

Verification
REQ-031 After reset, req=4'b1111 -> gnt=0001 one cycle later, gidx=0, busy=1, uio_out=1.
REQ-032 req=4'b1111 held with rel pulsed each grant -> grant order 0,1,2,3,0 with one IDLE cycle between grants.
REQ-033 req=4'b0100 held, no rel, MAX_HOLD=8 -> gnt=0100 for exactly 8 cycles, then gnt=0, and tout=1 for exactly 1 cycle.
REQ-034 Owner 1 drops req in the same cycle hold reaches the limit -> exit with tout=0.
REQ-035 rst_n pulsed low mid-GRANT -> gnt=0 and busy=0 before the next clk edge; after release, req=4'b1000 -> gidx=3.
REQ-036 ena=0 for 5 cycles during GRANT -> outputs frozen and hold unchanged; 256 grants -> uio_out wraps to 0.
